// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM engine: channel mode encoding and a
// width helper for counters and selectors that must be at least one bit wide.
package led_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } led_mode_e;

    function automatic int min_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow/active configuration, breathe ramp state and the
// registered PWM comparator output.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic             hw_clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             blink_phase,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic             wr_en,
    input  led_mode_e        wr_mode,
    input  logic [PWM_W-1:0] wr_duty,
    output logic             pwm_out
);

    led_mode_e        shadow_mode;
    led_mode_e        active_mode;
    logic [PWM_W-1:0] shadow_duty;
    logic [PWM_W-1:0] active_duty;
    logic [PWM_W-1:0] level;
    logic [PWM_W-1:0] level_nxt;
    logic [PWM_W-1:0] eff_duty;
    logic             dir_up;
    logic             dir_up_nxt;

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_mode <= MODE_OFF;
            shadow_duty <= '0;
        end else if (wr_en) begin
            shadow_mode <= wr_mode;
            shadow_duty <= wr_duty;
        end
    end

    // Active settings and the breathe ramp only move at frame boundaries.
    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            active_mode <= MODE_OFF;
            active_duty <= '0;
            level       <= '0;
            dir_up      <= 1'b1;
        end else if (frame_tick) begin
            active_mode <= shadow_mode;
            active_duty <= shadow_duty;
            level       <= level_nxt;
            dir_up      <= dir_up_nxt;
        end
    end

    // Ramp step uses the duty being loaded, so a lowered duty clamps at once.
    always_comb begin
        level_nxt  = level;
        dir_up_nxt = dir_up;
        if (shadow_mode == MODE_BREATHE) begin
            if (active_mode != MODE_BREATHE) begin
                level_nxt  = '0;
                dir_up_nxt = 1'b1;
            end else if (level > shadow_duty) begin
                level_nxt  = shadow_duty;
                dir_up_nxt = 1'b0;
            end else if (dir_up) begin
                if (level == shadow_duty) begin
                    dir_up_nxt = 1'b0;
                    level_nxt  = (shadow_duty == '0) ? '0 : shadow_duty - 1'b1;
                end else begin
                    level_nxt = level + 1'b1;
                end
            end else begin
                if (level == '0) begin
                    dir_up_nxt = 1'b1;
                    level_nxt  = (shadow_duty == '0) ? '0 : PWM_W'(1);
                end else begin
                    level_nxt = level - 1'b1;
                end
            end
        end
    end

    always_comb begin
        eff_duty = '0;
        case (active_mode)
            MODE_OFF:     eff_duty = '0;
            MODE_STATIC:  eff_duty = active_duty;
            MODE_BLINK:   eff_duty = blink_phase ? active_duty : '0;
            MODE_BREATHE: eff_duty = level;
            default:      eff_duty = '0;
        endcase
    end

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= (eff_duty > pwm_cnt);
        end
    end

endmodule

// File: rtl/led_pwm_engine.sv
// Multi-channel LED PWM engine: shared prescaler, PWM counter and blink phase
// driving N_CH independent channel slices.
module led_pwm_engine
    import led_pwm_pkg::*;
#(
    parameter int N_CH         = 3,
    parameter int PWM_W        = 8,
    parameter int PRESC        = 256,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                       hw_clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [min_width(N_CH)-1:0] cfg_ch,
    input  logic [1:0]                 cfg_mode,
    input  logic [PWM_W-1:0]           cfg_duty,
    output logic [N_CH-1:0]            pwm_out,
    output logic                       frame_tick
);

    localparam int CH_W    = min_width(N_CH);
    localparam int PRESC_W = min_width(PRESC);
    localparam int BLINK_W = min_width(BLINK_FRAMES);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [PRESC_W-1:0] presc_cnt;
    logic [PWM_W-1:0]   pwm_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic               step;

    assign step       = (presc_cnt == PRESC_LAST);
    assign frame_tick = step && (pwm_cnt == '1);

    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            presc_cnt <= step ? '0 : presc_cnt + 1'b1;
            if (step) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

    // Blink phase flips once every BLINK_FRAMES completed frames.
    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_W(PWM_W)
        ) u_ch (
            .hw_clk      (hw_clk),
            .rst_n       (rst_n),
            .frame_tick  (frame_tick),
            .blink_phase (blink_phase),
            .pwm_cnt     (pwm_cnt),
            .wr_en       (cfg_we && (cfg_ch == CH_W'(i))),
            .wr_mode     (led_mode_e'(cfg_mode)),
            .wr_duty     (cfg_duty),
            .pwm_out     (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_led_pwm_engine.sv
// Self-checking bench for led_pwm_engine: arithmetic reference model checked
// every cycle, directed frame-count scenarios and randomized configuration.
module tb_led_pwm_engine;

    localparam int N_CH         = 3;
    localparam int PWM_W        = 4;
    localparam int PRESC        = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int STEPS        = 1 << PWM_W;
    localparam int FRAME        = PRESC * STEPS;

    localparam int M_OFF     = 0;
    localparam int M_STATIC  = 1;
    localparam int M_BLINK   = 2;
    localparam int M_BREATHE = 3;

    logic             hw_clk   = 1'b0;
    logic             rst_n    = 1'b0;
    logic             cfg_we   = 1'b0;
    logic [1:0]       cfg_ch   = '0;
    logic [1:0]       cfg_mode = '0;
    logic [PWM_W-1:0] cfg_duty = '0;
    logic [N_CH-1:0]  pwm_out;
    logic             frame_tick;

    int tests = 0;
    int fails = 0;

    int              m_k   = 0;
    logic [N_CH-1:0] m_pwm = '0;
    int              sh_mode [N_CH];
    int              sh_duty [N_CH];
    int              ac_mode [N_CH];
    int              ac_duty [N_CH];
    int              lvl     [N_CH];
    bit              up      [N_CH];

    led_pwm_engine #(
        .N_CH         (N_CH),
        .PWM_W        (PWM_W),
        .PRESC        (PRESC),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .hw_clk     (hw_clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_duty   (cfg_duty),
        .pwm_out    (pwm_out),
        .frame_tick (frame_tick)
    );

    always #5 hw_clk = ~hw_clk;

    task automatic check_output(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int model_eff(input int i, input int phase);
        case (ac_mode[i])
            M_STATIC:  return ac_duty[i];
            M_BLINK:   return (phase != 0) ? ac_duty[i] : 0;
            M_BREATHE: return lvl[i];
            default:   return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_k   = 0;
        m_pwm = '0;
        for (int i = 0; i < N_CH; i++) begin
            sh_mode[i] = M_OFF;
            sh_duty[i] = 0;
            ac_mode[i] = M_OFF;
            ac_duty[i] = 0;
            lvl[i]     = 0;
            up[i]      = 1'b1;
        end
    endtask

    // Everything is derived from the number of clock edges since reset release.
    task automatic model_step();
        int pc    = (m_k / PRESC) % STEPS;
        int phase = ((m_k / FRAME) / BLINK_FRAMES) % 2;
        bit tick  = (m_k % FRAME) == (FRAME - 1);
        for (int i = 0; i < N_CH; i++) begin
            m_pwm[i] = (model_eff(i, phase) > pc);
        end
        if (tick) begin
            for (int i = 0; i < N_CH; i++) begin
                if (sh_mode[i] == M_BREATHE) begin
                    if (ac_mode[i] != M_BREATHE) begin
                        lvl[i] = 0;
                        up[i]  = 1'b1;
                    end else if (lvl[i] > sh_duty[i]) begin
                        lvl[i] = sh_duty[i];
                        up[i]  = 1'b0;
                    end else if (up[i] && lvl[i] == sh_duty[i]) begin
                        up[i]  = 1'b0;
                        lvl[i] = (sh_duty[i] > 0) ? sh_duty[i] - 1 : 0;
                    end else if (up[i]) begin
                        lvl[i] = lvl[i] + 1;
                    end else if (lvl[i] == 0) begin
                        up[i]  = 1'b1;
                        lvl[i] = (sh_duty[i] < 1) ? sh_duty[i] : 1;
                    end else begin
                        lvl[i] = lvl[i] - 1;
                    end
                end
                ac_mode[i] = sh_mode[i];
                ac_duty[i] = sh_duty[i];
            end
        end
        if (cfg_we && int'(cfg_ch) < N_CH) begin
            sh_mode[int'(cfg_ch)] = int'(cfg_mode);
            sh_duty[int'(cfg_ch)] = int'(cfg_duty);
        end
        m_k++;
    endtask

    always @(posedge hw_clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step();
        end
    end

    always @(negedge hw_clk) begin
        if (rst_n) begin
            check_output("pwm_out", int'(pwm_out), int'(m_pwm));
            check_output("frame_tick", int'(frame_tick), int'((m_k % FRAME) == (FRAME - 1)));
        end
    end

    task automatic apply_stimulus(input int ch, input int mode, input int duty);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_mode = 2'(mode);
        cfg_duty = PWM_W'(duty);
        @(negedge hw_clk);
        cfg_we   = 1'b0;
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge hw_clk);
            n++;
        end while (!frame_tick && n < 100);
        if (!frame_tick) check_output("tick_timeout", 0, 1);
    endtask

    task automatic do_reset();
        cfg_we = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(negedge hw_clk);
        rst_n  = 1'b1;
    endtask

    // Starts at a frame_tick sample and ends on the next one; wr_at >= 0 issues a write.
    task automatic expect_frame(input string name, input int ch, input int exp_hi,
                                input int wr_at, input int wr_ch, input int wr_mode,
                                input int wr_duty);
        int hi = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i == wr_at) begin
                cfg_we   = 1'b1;
                cfg_ch   = 2'(wr_ch);
                cfg_mode = 2'(wr_mode);
                cfg_duty = PWM_W'(wr_duty);
            end else begin
                cfg_we = 1'b0;
            end
            @(negedge hw_clk);
            hi += int'(pwm_out[ch]);
        end
        cfg_we = 1'b0;
        check_output(name, hi, exp_hi);
    endtask

    initial begin
        int n;
        int bl_exp [6]  = '{0, 30, 30, 0, 0, 30};
        int br_exp [14] = '{0, 2, 4, 6, 4, 2, 0, 2, 4, 6, 2, 0, 2, 0};

        repeat (2) @(negedge hw_clk);
        check_output("reset_pwm_out", int'(pwm_out), 0);
        check_output("reset_frame_tick", int'(frame_tick), 0);
        rst_n = 1'b1;

        n = 0;
        while (!frame_tick && n < 100) begin
            @(negedge hw_clk);
            n++;
        end
        check_output("first_tick_latency", n, FRAME - 1);
        n = 0;
        do begin
            @(negedge hw_clk);
            n++;
        end while (!frame_tick && n < 100);
        check_output("tick_period", n, FRAME);

        apply_stimulus(0, M_STATIC, 5);
        wait_tick();
        expect_frame("static_duty5", 0, 10, -1, 0, 0, 0);
        apply_stimulus(0, M_STATIC, 0);
        wait_tick();
        expect_frame("static_duty0", 0, 0, -1, 0, 0, 0);
        apply_stimulus(0, M_STATIC, 15);
        wait_tick();
        expect_frame("static_duty15", 0, 30, -1, 0, 0, 0);

        apply_stimulus(0, M_STATIC, 5);
        wait_tick();
        expect_frame("shadow_midframe_cur", 0, 10, 16, 0, M_STATIC, 8);
        expect_frame("shadow_midframe_next", 0, 16, -1, 0, 0, 0);
        expect_frame("shadow_tickwrite_cur", 0, 16, 0, 0, M_STATIC, 5);
        expect_frame("shadow_tickwrite_next", 0, 10, -1, 0, 0, 0);

        expect_frame("bad_channel_cur", 0, 10, 5, 3, M_STATIC, 15);
        expect_frame("bad_channel_next", 0, 10, -1, 0, 0, 0);

        apply_stimulus(0, M_STATIC, 15);
        wait_tick();
        repeat (4) @(negedge hw_clk);
        check_output("pre_reset_high", int'(pwm_out[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_reset_pwm_out", int'(pwm_out), 0);
        check_output("async_reset_frame_tick", int'(frame_tick), 0);
        repeat (2) @(negedge hw_clk);
        rst_n = 1'b1;
        wait_tick();
        for (int ch = 0; ch < N_CH; ch++) begin
            expect_frame("off_after_reset", ch, 0, -1, 0, 0, 0);
        end

        do_reset();
        apply_stimulus(1, M_BLINK, 15);
        wait_tick();
        for (int f = 0; f < 6; f++) begin
            expect_frame("blink_frame", 1, bl_exp[f], -1, 0, 0, 0);
        end

        do_reset();
        apply_stimulus(2, M_BREATHE, 3);
        wait_tick();
        for (int f = 0; f < 14; f++) begin
            expect_frame("breathe_frame", 2, br_exp[f], (f == 9) ? 16 : -1, 2, M_BREATHE, 1);
        end

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                cfg_we   = 1'b1;
                cfg_ch   = 2'($urandom_range(0, 3));
                cfg_mode = 2'($urandom_range(0, 3));
                cfg_duty = PWM_W'($urandom_range(0, STEPS - 1));
            end else begin
                cfg_we = 1'b0;
            end
            if (c == 2000) begin
                rst_n = 1'b0;
                @(negedge hw_clk);
                rst_n = 1'b1;
            end
            @(negedge hw_clk);
        end
        cfg_we = 1'b0;
        repeat (2) @(negedge hw_clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
